// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave.
// Optional byte-lane strobes are enabled by defining APB_PSTRB_EN.
package apb_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int WAIT_CNT_W = 4;

    // Number of low PADDR bits that select a byte within one data word.
    function automatic int lane_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word-organised storage: synchronous write with per-byte enables, registered read port.
// Contents are deliberately not reset; the read register holds until the next read.
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [DATA_WIDTH-1:0]   wr_dat,
    input  logic                    rd_en,
    input  logic [AW-1:0]           rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_dat
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_dat_q;
    logic [DATA_WIDTH-1:0] rd_dat_d;

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_addr][b*8 +: 8] <= wr_dat[b*8 +: 8];
                end
            end
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB3 RAM slave with programmable wait states and PSLVERR on out-of-range word index.
// Define APB_PSTRB_EN to add the PSTRB port and byte-lane write masking.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int SHIFT  = lane_shift(DATA_WIDTH);
    localparam int IDX_W  = ADDR_WIDTH - SHIFT;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]          DEPTH_L = (IDX_W + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0]   WS_L    = WAIT_CNT_W'(WAIT_STATES);

    state_t                  state_q,   state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q,     cnt_d;
    logic [IDX_W-1:0]        addr_q,    addr_d;
    logic                    write_q,   write_d;
    logic                    err_q,     err_d;
    logic [DATA_WIDTH-1:0]   wdat_q,    wdat_d;
    logic [BYTES-1:0]        strb_q,    strb_d;
    logic                    pready_q,  pready_d;
    logic                    pslverr_q, pslverr_d;
    logic                    rd_vld_q,  rd_vld_d;

    logic [IDX_W-1:0]        bus_idx;
    logic                    bus_in_range;
    logic [BYTES-1:0]        bus_strb;
    logic [IDX_W-1:0]        rd_idx;
    logic                    mem_we;
    logic                    mem_re;
    logic [DATA_WIDTH-1:0]   mem_rd_dat;
    logic                    unused_bits;

    assign bus_idx      = PADDR[ADDR_WIDTH-1:SHIFT];
    assign bus_in_range = ({1'b0, bus_idx} < DEPTH_L);

`ifdef APB_PSTRB_EN
    assign bus_strb = PSTRB;
`else
    assign bus_strb = '1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        err_d     = err_q;
        wdat_d    = wdat_q;
        strb_d    = strb_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        rd_vld_d  = rd_vld_q;
        rd_idx    = addr_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = WAIT;
                    addr_d  = bus_idx;
                    write_d = PWRITE;
                    err_d   = !bus_in_range;
                    wdat_d  = PWDATA;
                    strb_d  = bus_strb;
                    cnt_d   = WS_L;
                    // Zero-wait: the response must be registered at the setup edge itself.
                    if (WS_L == '0) begin
                        pready_d  = 1'b1;
                        pslverr_d = !bus_in_range;
                        rd_vld_d  = !PWRITE && bus_in_range;
                        mem_re    = !PWRITE && bus_in_range;
                        rd_idx    = bus_idx;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    rd_vld_d  = 1'b0;
                end else if (pready_q) begin
                    if (PENABLE) begin
                        mem_we    = write_q && !err_q && !PRESET;
                        state_d   = IDLE;
                        pready_d  = 1'b0;
                        pslverr_d = 1'b0;
                        rd_vld_d  = 1'b0;
                    end
                end else if (PENABLE && (cnt_q != '0)) begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                    if (cnt_q == WAIT_CNT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        rd_vld_d  = !write_q && !err_q;
                        mem_re    = !write_q && !err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            wdat_q    <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            err_q     <= err_d;
            wdat_q    <= wdat_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (MEM_AW)
    ) u_array (
        .clk     (PCLK),
        .wr_en   (mem_we),
        .wr_addr (addr_q[MEM_AW-1:0]),
        .wr_be   (strb_q),
        .wr_dat  (wdat_q),
        .rd_en   (mem_re),
        .rd_addr (rd_idx[MEM_AW-1:0]),
        .rd_dat  (mem_rd_dat)
    );

    // The array's read register is not reset, so PRDATA is qualified by a reset flop.
    assign PRDATA  = rd_vld_q ? mem_rd_dat : '0;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

    assign unused_bits = ^{PADDR, rd_idx, addr_q};

endmodule
